// File: rtl/barrido_comparador.sv
// barrido_comparador: start/done controlled sweep of a comparator operand,
// tallying matches into a saturating count for the downstream decoder.
module barrido_comparador #(
    parameter int WIDTH = 6,
    parameter int LAST  = 62,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pausa,
    input  logic             limpiar,
    input  logic             coincidencia,
    output logic [WIDTH-1:0] valor,
    output logic [CNT_W-1:0] cuenta,
    output logic [WIDTH-1:0] ultimo,
    output logic             ocupado,
    output logic             listo,
    output logic             desborde
);
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} estado_t;
    localparam logic [WIDTH-1:0] VALOR_FIN = WIDTH'(LAST);
    localparam logic [CNT_W-1:0] CUENTA_MAX = '1;
    estado_t estado, estadoSig;
    logic    arranque, avanza, enFin;
    assign enFin    = (valor == VALOR_FIN);
    assign arranque = start && (estado == IDLE || estado == DONE);
    assign avanza   = (estado == SWEEP) && !pausa;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= IDLE;
            valor    <= '0;
            cuenta   <= '0;
            ultimo   <= '0;
            desborde <= 1'b0;
        end else begin
            estado <= estadoSig;
            if (limpiar || arranque) begin
                valor    <= '0;
                cuenta   <= '0;
                ultimo   <= '0;
                desborde <= 1'b0;
            end else if (avanza) begin
                // the match belongs to the operand presented this cycle
                if (coincidencia) begin
                    ultimo <= valor;
                    if (cuenta == CUENTA_MAX) desborde <= 1'b1;
                    else cuenta <= cuenta + 1'b1;
                end
                if (!enFin) valor <= valor + 1'b1;
            end
        end
    end
    always_comb begin
        estadoSig = limpiar              ? IDLE :
                    (estado == SWEEP)    ? ((avanza && enFin) ? DONE : SWEEP) :
                    (estado == DONE || estado == IDLE) ? (start ? SWEEP : estado) :
                    IDLE;
    end
    always_comb begin
        ocupado = (estado == SWEEP);
        listo   = (estado == DONE);
    end
endmodule

// File: tb/tb_barrido_comparador.sv
// tb_barrido_comparador: directed sweeps checked every cycle against a hit-counting
// model, plus literal expectations for the test-plan scenarios and a LAST=0 build.
module tb_barrido_comparador;
    localparam int LAST = 62;
    logic       clk = 1'b0;
    logic       rst_n, start, pausa, limpiar, coincidencia;
    logic [5:0] valor, ultimo;
    logic [2:0] cuenta;
    logic       ocupado, listo, desborde;
    logic       start0;
    logic [5:0] valor0, ultimo0;
    logic [2:0] cuenta0;
    logic       ocupado0, listo0, desborde0;
    int         checks = 0, errors = 0, modo = 0;
    bit         checkOn = 1'b0;
    int         mPhase = 0, mValor = 0, mHits = 0, mUltimo = 0;

    barrido_comparador #(.WIDTH(6), .LAST(LAST), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pausa(pausa), .limpiar(limpiar),
        .coincidencia(coincidencia), .valor(valor), .cuenta(cuenta), .ultimo(ultimo),
        .ocupado(ocupado), .listo(listo), .desborde(desborde)
    );
    barrido_comparador #(.WIDTH(6), .LAST(0), .CNT_W(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .pausa(1'b0), .limpiar(1'b0),
        .coincidencia(1'b1), .valor(valor0), .cuenta(cuenta0), .ultimo(ultimo0),
        .ocupado(ocupado0), .listo(listo0), .desborde(desborde0)
    );

    always #5 clk = ~clk;
    // modo 0: comparator matches 22, modo 1: always matches
    assign coincidencia = (modo == 1) || (modo == 0 && valor == 6'd22);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // model: phase 0 idle, 1 sweeping, 2 done; count derived from total hits
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || limpiar) begin
            mPhase <= 0; mValor <= 0; mHits <= 0; mUltimo <= 0;
        end else if (mPhase != 1) begin
            if (start) begin
                mPhase <= 1; mValor <= 0; mHits <= 0; mUltimo <= 0;
            end
        end else if (!pausa) begin
            if (modo == 1 || (modo == 0 && mValor == 22)) begin
                mHits <= mHits + 1; mUltimo <= mValor;
            end
            if (mValor == LAST) mPhase <= 2;
            else mValor <= mValor + 1;
        end
    end

    always @(negedge clk) begin
        if (checkOn) begin
            chk("valor", int'(valor), mValor);
            chk("cuenta", int'(cuenta), mHits > 7 ? 7 : mHits);
            chk("ultimo", int'(ultimo), mUltimo);
            chk("desborde", int'(desborde), int'(mHits > 7));
            chk("ocupado", int'(ocupado), int'(mPhase == 1));
            chk("listo", int'(listo), int'(mPhase == 2));
        end
    end

    task automatic startPulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int exp, input bit conPausa);
        int n = 0;
        int left = conPausa ? 5 : 0;
        while (ocupado && n < 300) begin
            n++;
            if (left > 0 && valor == 6'd21) begin
                pausa = 1'b1; left--;
            end else pausa = 1'b0;
            @(negedge clk);
        end
        pausa = 1'b0;
        chk({tag, " ciclos"}, n, exp);
    endtask

    task automatic waitValor(input int v);
        int n = 0;
        while (int'(valor) != v && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) chk("timeout valor", int'(valor), v);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; pausa = 1'b0; limpiar = 1'b0; start0 = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk("reset valor", int'(valor), 0);
        chk("reset listo", int'(listo), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; checkOn = 1'b1;
        modo = 0;
        startPulse();
        waitDone("barrido22", 63, 1'b0);
        chk("barrido22 cuenta", int'(cuenta), 1);
        chk("barrido22 ultimo", int'(ultimo), 22);
        chk("barrido22 desborde", int'(desborde), 0);
        chk("barrido22 listo", int'(listo), 1);
        modo = 1;
        startPulse();
        chk("reinicio valor", int'(valor), 0);
        chk("reinicio cuenta", int'(cuenta), 0);
        chk("reinicio listo", int'(listo), 0);
        chk("reinicio ocupado", int'(ocupado), 1);
        waitDone("saturacion", 63, 1'b0);
        chk("saturacion cuenta", int'(cuenta), 7);
        chk("saturacion desborde", int'(desborde), 1);
        chk("saturacion ultimo", int'(ultimo), 62);
        modo = 0;
        startPulse();
        waitDone("pausa", 68, 1'b1);
        chk("pausa cuenta", int'(cuenta), 1);
        chk("pausa ultimo", int'(ultimo), 22);
        startPulse();
        waitValor(5);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start ignorado valor", int'(valor), 6);
        chk("start ignorado ocupado", int'(ocupado), 1);
        limpiar = 1'b1; start = 1'b1;
        @(negedge clk); limpiar = 1'b0; start = 1'b0;
        chk("limpiar ocupado", int'(ocupado), 0);
        chk("limpiar valor", int'(valor), 0);
        chk("limpiar listo", int'(listo), 0);
        startPulse();
        waitValor(30);
        #2 rst_n = 1'b0;
        #1 chk("async valor", int'(valor), 0);
        chk("async ultimo", int'(ultimo), 0);
        chk("async cuenta", int'(cuenta), 0);
        chk("async ocupado", int'(ocupado), 0);
        chk("async listo", int'(listo), 0);
        chk("async desborde", int'(desborde), 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        chk("last0 ocupado", int'(ocupado0), 1);
        chk("last0 valor", int'(valor0), 0);
        @(negedge clk);
        chk("last0 listo", int'(listo0), 1);
        chk("last0 ocupado fin", int'(ocupado0), 0);
        chk("last0 valor fin", int'(valor0), 0);
        chk("last0 cuenta", int'(cuenta0), 1);
        chk("last0 desborde", int'(desborde0), 0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
